// File: rtl/lc3_alu_pkg.sv
// lc3_alu_pkg: shared opcodes, FSM state encoding and NZP constants for lc3_alu_seq.
// Latency: n/a (declarations and one pure combinational helper).
// Backpressure: n/a.
package lc3_alu_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_AND   = 3'b001;
    localparam logic [2:0] ALU_NOT   = 3'b010;
    localparam logic [2:0] ALU_PASSA = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_SHL   = 3'b110;
    localparam logic [2:0] ALU_MUL   = 3'b111;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One-hot condition codes from the result's sign bit and zero test.
    function automatic logic [2:0] nzp_of(input logic msb, input logic is_zero);
        if (msb) begin
            return NZP_N;
        end else if (is_zero) begin
            return NZP_Z;
        end else begin
            return NZP_P;
        end
    endfunction

endpackage

// File: rtl/lc3_alu_mul_iter.sv
// lc3_alu_mul_iter: iterative shift-add multiplier, low W bits of a*b.
// Latency: start at edge t, done asserted combinationally during the W-th running cycle (product valid then).
// Backpressure: none; caller must consume product in the done cycle. abort drops an op in flight.
//
// Ports: clk/rst (async active-high), abort (sync cancel), start (load operands),
//        mcand_in/mplier_in (operands), done (last iteration this cycle), product (result on done).
module lc3_alu_mul_iter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         abort,
    input  logic         start,
    input  logic [W-1:0] mcand_in,
    input  logic [W-1:0] mplier_in,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic          run_q,    run_d;
    logic [W-1:0]  acc_q,    acc_d;
    logic [W-1:0]  mcand_q,  mcand_d;
    logic [W-1:0]  mplier_q, mplier_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [W-1:0]  acc_sum;

    always_comb begin
        run_d    = run_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        // Partial product of the current multiplier LSB; exposed directly so the
        // final iteration's sum can be captured by the caller in the same edge.
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
        product = acc_sum;
        done    = run_q && (cnt_q == CW'(W - 1));

        if (abort) begin
            run_d = 1'b0;
        end else if (start) begin
            run_d    = 1'b1;
            acc_d    = '0;
            mcand_d  = mcand_in;
            mplier_d = mplier_in;
            cnt_d    = '0;
        end else if (run_q) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            run_q    <= run_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/lc3_alu_seq.sv
// lc3_alu_seq: registered LC-3 ALU with valid/ready handshake, NZP codes and tri-state bus view.
// Latency: 1 cycle for single-cycle ops; W+1 cycles for MUL (accept edge to out_valid visible).
// Backpressure: result held while out_valid && !out_ready; in_ready = IDLE || (DONE && out_ready).
//
// Build option: define LC3_ALU_MUL_EN to include the iterative multiplier and BUSY state.
// Without it, opcode 111 completes in one cycle with result=0, nzp=010, op_err=1.
// Ports: clk, rst (async active-high), flush (sync abort), in_valid/in_ready, aluk, ir_slice,
//        sr1, sr2, out_valid/out_ready, result, nzp, op_err, gate_alu_en, alu (tri-state result).
module lc3_alu_seq
    import lc3_alu_pkg::*;
#(
    parameter int W     = 16,
    parameter int IMM_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     aluk,
    input  logic [IMM_W:0] ir_slice,
    input  logic [W-1:0]   sr1,
    input  logic [W-1:0]   sr2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   result,
    output logic [2:0]     nzp,
    output logic           op_err,
    input  logic           gate_alu_en,
    output wire  [W-1:0]   alu
);

    localparam int SH_W = $clog2(W);
    localparam logic [W-1:0] W_LIM = W[W-1:0];

    state_t       state_q,  state_d;
    logic [W-1:0] result_q, result_d;
    logic [2:0]   nzp_q,    nzp_d;
    logic         op_err_q, op_err_d;

    logic [W-1:0] opb;
    logic [W-1:0] alu_res;
    logic         accept;

`ifdef LC3_ALU_MUL_EN
    logic         mul_start;
    logic         mul_done;
    logic [W-1:0] mul_product;

    lc3_alu_mul_iter #(
        .W (W)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .abort     (flush),
        .start     (mul_start),
        .mcand_in  (sr1),
        .mplier_in (opb),
        .done      (mul_done),
        .product   (mul_product)
    );
`endif

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign nzp       = nzp_q;
    assign op_err    = op_err_q;
    assign alu       = gate_alu_en ? result_q : {W{1'bz}};

    // Operand B and single-cycle datapath.
    always_comb begin
        opb = ir_slice[IMM_W] ? {{(W - IMM_W){ir_slice[IMM_W-1]}}, ir_slice[IMM_W-1:0]} : sr2;

        alu_res = '0;
        case (aluk)
            ALU_ADD:   alu_res = sr1 + opb;
            ALU_AND:   alu_res = sr1 & opb;
            ALU_NOT:   alu_res = ~sr1;
            ALU_PASSA: alu_res = sr1;
            ALU_XOR:   alu_res = sr1 ^ opb;
            ALU_OR:    alu_res = sr1 | opb;
            // Out-of-range shift amounts flush every bit out.
            ALU_SHL:   alu_res = (opb >= W_LIM) ? '0 : (sr1 << opb[SH_W-1:0]);
            default:   alu_res = '0;
        endcase
    end

    // Next-state and register updates. flush wins over any handshake.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        nzp_d    = nzp_q;
        op_err_d = op_err_q;
        accept   = in_valid && in_ready && !flush;
`ifdef LC3_ALU_MUL_EN
        mul_start = 1'b0;
`endif

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
`ifdef LC3_ALU_MUL_EN
                        if (aluk == ALU_MUL) begin
                            state_d   = ST_BUSY;
                            mul_start = 1'b1;
                        end else begin
                            state_d  = ST_DONE;
                            result_d = alu_res;
                            nzp_d    = nzp_of(alu_res[W-1], alu_res == '0);
                            op_err_d = 1'b0;
                        end
`else
                        state_d  = ST_DONE;
                        result_d = alu_res;
                        nzp_d    = nzp_of(alu_res[W-1], alu_res == '0);
                        op_err_d = (aluk == ALU_MUL);
`endif
                    end else if ((state_q == ST_DONE) && out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef LC3_ALU_MUL_EN
                ST_BUSY: begin
                    if (mul_done) begin
                        state_d  = ST_DONE;
                        result_d = mul_product;
                        nzp_d    = nzp_of(mul_product[W-1], mul_product == '0);
                        op_err_d = 1'b0;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            nzp_q    <= NZP_Z;
            op_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            nzp_q    <= nzp_d;
            op_err_q <= op_err_d;
        end
    end

endmodule

// File: tb/tb_lc3_alu_seq.sv
// tb_lc3_alu_seq: directed plus random checks of lc3_alu_seq against an arithmetic reference model.
// Latency: checks 1-cycle ops and W+1-cycle MUL (when LC3_ALU_MUL_EN is defined).
// Backpressure: exercises out_ready hold, same-cycle re-accept, flush and async reset.
module tb_lc3_alu_seq;

`ifdef LC3_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  aluk;
    logic [5:0]  ir_slice;
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [2:0]  nzp;
    logic        op_err;
    logic        gate_alu_en;
    wire  [15:0] alu;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] last_res;

    always #5 clk = ~clk;

    lc3_alu_seq #(.W(16), .IMM_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .aluk        (aluk),
        .ir_slice    (ir_slice),
        .sr1         (sr1),
        .sr2         (sr2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .nzp         (nzp),
        .op_err      (op_err),
        .gate_alu_en (gate_alu_en),
        .alu         (alu)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode rules.
    function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic [5:0] ir, output logic [15:0] r, output logic [2:0] n,
                                  output logic e, output int lat);
        longint unsigned ua, ub, v;
        int imm;
        ua  = longint'(a);
        imm = int'(ir[4:0]);
        if (imm >= 16) imm = imm - 32;
        ub  = ir[5] ? longint'((imm + 65536) % 65536) : longint'(b);
        v   = 0;
        e   = 1'b0;
        lat = 1;
        case (op)
            3'd0: v = ua + ub;
            3'd1: v = ua & ub;
            3'd2: v = 65535 - ua;
            3'd3: v = ua;
            3'd4: v = ua ^ ub;
            3'd5: v = ua | ub;
            3'd6: v = (ub >= 16) ? 0 : ua * (longint'(1) << ub);
            default: begin
                if (MUL_EN) begin
                    v   = ua * ub;
                    lat = 17;
                end else begin
                    v = 0;
                    e = 1'b1;
                end
            end
        endcase
        r = 16'(v % 65536);
        n = (r >= 16'h8000) ? 3'b100 : ((r == 16'h0000) ? 3'b010 : 3'b001);
    endfunction

    function automatic logic [2:0] nzp_ref(input logic [15:0] r);
        return (r >= 16'h8000) ? 3'b100 : ((r == 16'h0000) ? 3'b010 : 3'b001);
    endfunction

    task automatic scramble();
        sr1      = 16'($urandom);
        sr2      = 16'($urandom);
        ir_slice = 6'($urandom);
        aluk     = 3'($urandom);
    endtask

    // Issue one op with out_ready=1, wait for its result and check it against the model.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [5:0] ir);
        logic [15:0] er;
        logic [2:0]  en;
        logic        ee;
        int          el;
        int          k;
        bit          rdy_busy;
        model(op, a, b, ir, er, en, ee, el);
        @(negedge clk);
        aluk = op; sr1 = a; sr2 = b; ir_slice = ir; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        k = 0;
        rdy_busy = 1'b0;
        do begin
            @(negedge clk);
            k++;
            if (!out_valid && in_ready) rdy_busy = 1'b1;
        end while (!out_valid && k < 40);
        chk({tag, "_latency"}, 32'(k), 32'(el));
        chk({tag, "_ready_while_busy"}, 32'(rdy_busy), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'(er));
        chk({tag, "_nzp"}, 32'(nzp), 32'(en));
        chk({tag, "_op_err"}, 32'(op_err), 32'(ee));
        last_res = er;
    endtask

    initial begin
        logic [15:0] er, keep;
        logic [2:0]  en;
        logic        ee;
        int          el;
        bit          ok;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        aluk = 3'd0; ir_slice = 6'd0; sr1 = 16'd0; sr2 = 16'd0; gate_alu_en = 1'b1;
        last_res = 16'd0;

        // Reset state
        #2;
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_nzp", 32'(nzp), 32'b010);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op_err", 32'(op_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed ops: immediate ADD, NOT, OR zero, MUL, MUL overflow, SHL limits
        run_op("add_imm", 3'b000, 16'h0005, 16'h1234, 6'b111111);
        run_op("not", 3'b010, 16'h00FF, 16'h0000, 6'b000000);
        run_op("or_zero", 3'b101, 16'h0000, 16'h0000, 6'b000000);
        run_op("mul_3x7", 3'b111, 16'h0003, 16'h0007, 6'b000000);
        run_op("mul_ovf", 3'b111, 16'h0100, 16'h0100, 6'b000000);
        run_op("shl_16", 3'b110, 16'h0001, 16'h0010, 6'b000000);
        run_op("shl_15", 3'b110, 16'h0001, 16'h000F, 6'b000000);
        run_op("and_imm", 3'b001, 16'hFFFF, 16'h0000, 6'b101010);

        // Tri-state bus view
        run_op("pass", 3'b011, 16'hA5C3, 16'h0000, 6'b000000);
        @(negedge clk);
        n_checks++;
        assert (alu === 16'hA5C3) else begin
            n_fail++;
            $error("FAIL gate_on: observed %h expected a5c3", alu);
        end
        gate_alu_en = 1'b0;
        #1;
        n_checks++;
        assert (alu === 16'hzzzz) else begin
            n_fail++;
            $error("FAIL gate_off: observed %h expected zzzz", alu);
        end
        gate_alu_en = 1'b1;

        // Backpressure: hold out_ready low, then release with a same-cycle new op
        model(3'b100, 16'h0F0F, 16'hFF00, 6'd0, er, en, ee, el);
        @(negedge clk);
        aluk = 3'b100; sr1 = 16'h0F0F; sr2 = 16'hFF00; ir_slice = 6'd0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(out_valid === 1'b1 && in_ready === 1'b0 && result === er && nzp === en)) ok = 1'b0;
        end
        chk("bp_hold_stable", 32'(ok), 32'd1);
        chk("bp_result", 32'(result), 32'(er));
        model(3'b000, 16'h7000, 16'h1000, 6'd0, er, en, ee, el);
        aluk = 3'b000; sr1 = 16'h7000; sr2 = 16'h1000; ir_slice = 6'd0; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk("bp_reaccept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        @(negedge clk);
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_result", 32'(result), 32'(er));
        chk("bp_next_nzp", 32'(nzp), 32'(en));

        // Flush eight cycles into a MUL; a competing in_valid must not be taken
        run_op("pre_flush", 3'b000, 16'h1200, 16'h0034, 6'd0);
        keep = MUL_EN ? last_res : 16'h0000;
        @(negedge clk);
        aluk = 3'b111; sr1 = 16'h0003; sr2 = 16'h0005; ir_slice = 6'd0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        aluk = 3'b000; sr1 = 16'h0001; sr2 = 16'h0001; ir_slice = 6'd0;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_result_kept", 32'(result), 32'(keep));
        chk("flush_nzp_kept", 32'(nzp), 32'(nzp_ref(keep)));
        ok = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        chk("flush_no_late_valid", 32'(ok), 32'd0);
        chk("flush_result_final", 32'(result), 32'(keep));

        // Async reset in the middle of a MUL
        run_op("pre_rst", 3'b000, 16'h4000, 16'h0321, 6'd0);
        @(negedge clk);
        aluk = 3'b111; sr1 = 16'h00FF; sr2 = 16'h0101; ir_slice = 6'd0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_result", 32'(result), 32'h0);
        chk("mid_rst_nzp", 32'(nzp), 32'b010);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_op_err", 32'(op_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        run_op("post_rst_mul", 3'b111, 16'h1234, 16'h0011, 6'd0);

        // Random ops against the model
        for (int i = 0; i < 40; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 6'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
